// File: rtl/svi_asm_pkg.sv
// Shared types and sizing for the serial-bit word assembler and its output FIFO.
package svi_asm_pkg;

  localparam int WORD_WIDTH = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(WORD_WIDTH);
  localparam int PTR_W      = $clog2(FIFO_DEPTH) + 1;

  typedef logic [WORD_WIDTH-1:0] word_t;

  typedef enum logic {
    IDLE,
    COLLECT
  } asm_state_e;

endpackage

// File: rtl/svi_word_assembler_if.sv
// Bit-stream input, word handshake output and status signals of the word assembler.
interface svi_word_assembler_if
  import svi_asm_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
);

  logic                   en;
  logic                   i_bit;
  logic                   i_bit_vld;
  logic                   i_sync;
  logic                   i_word_rdy;
  logic [WIDTH-1:0]       o_word;
  logic                   o_word_vld;
  logic [$clog2(DEPTH):0] o_level;
  logic                   o_overflow;
  logic                   o_busy;

  modport master (
    output en, i_bit, i_bit_vld, i_sync, i_word_rdy,
    input  o_word, o_word_vld, o_level, o_overflow, o_busy
  );

  modport slave (
    input  en, i_bit, i_bit_vld, i_sync, i_word_rdy,
    output o_word, o_word_vld, o_level, o_overflow, o_busy
  );

endinterface

// File: rtl/svi_word_fifo.sv
// Small FIFO of completed words; push while full drops the word and sets a sticky overflow
// unless a pop frees the slot in the same cycle.
module svi_word_fifo
  import svi_asm_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_word,
  input  logic                   i_pop_rdy,
  output logic [WIDTH-1:0]       o_word,
  output logic                   o_word_vld,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overflow
);

  localparam int PTR_BITS = $clog2(DEPTH) + 1;
  localparam int IDX_BITS = PTR_BITS - 1;

  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic                overflow_q, overflow_d;
  logic                empty, full, do_pop, do_push;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_BITS-1] != rd_ptr_q[PTR_BITS-1]) &&
                   (wr_ptr_q[IDX_BITS-1:0] == rd_ptr_q[IDX_BITS-1:0]);
  assign do_pop  = !empty && i_pop_rdy;
  assign do_push = i_push && (!full || do_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    overflow_d = overflow_q;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
    end
    if (do_push) begin
      mem_d[wr_ptr_q[IDX_BITS-1:0]] = i_push_word;
      wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
    end
    if (i_push && !do_push) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_q      <= '{default: '0};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_word     = empty ? '0 : mem_q[rd_ptr_q[IDX_BITS-1:0]];
  assign o_word_vld = !empty;
  assign o_level    = wr_ptr_q - rd_ptr_q;
  assign o_overflow = overflow_q;

endmodule

// File: rtl/svi_word_assembler.sv
// Reassembles an LSB-first serial bit stream into WIDTH-bit words and queues them for a
// valid/ready consumer.
module svi_word_assembler
  import svi_asm_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input logic                 i_clk,
  input logic                 i_arst,
  svi_word_assembler_if.slave bus
);

  localparam int                   CNT_BITS = $clog2(WIDTH);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WIDTH - 1);

  asm_state_e          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-2:0]    shift_q, shift_d;
  logic                accept;
  logic                push;
  logic [WIDTH-1:0]    push_word;

  assign accept    = bus.en && bus.i_bit_vld;
  assign push_word = {bus.i_bit, shift_q};

  // Sync clears the partial word first; a bit arriving with it becomes index 0 of a new word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    push    = 1'b0;
    if (bus.i_sync) begin
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
      if (accept) begin
        shift_d[0] = bus.i_bit;
        cnt_d      = CNT_BITS'(1);
        state_d    = COLLECT;
      end
    end else if (accept) begin
      if (cnt_q == CNT_LAST) begin
        push    = 1'b1;
        cnt_d   = '0;
        shift_d = '0;
        state_d = IDLE;
      end else begin
        shift_d[cnt_q] = bus.i_bit;
        cnt_d          = cnt_q + CNT_BITS'(1);
        state_d        = COLLECT;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign bus.o_busy = (state_q == COLLECT);

  svi_word_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_arst     (i_arst),
    .i_push     (push),
    .i_push_word(push_word),
    .i_pop_rdy  (bus.i_word_rdy),
    .o_word     (bus.o_word),
    .o_word_vld (bus.o_word_vld),
    .o_level    (bus.o_level),
    .o_overflow (bus.o_overflow)
  );

endmodule

// File: tb/tb_svi_word_assembler.sv
// Self-checking bench: directed scenarios plus random traffic compared against a
// queue-based model of bit collection and word buffering.
module tb_svi_word_assembler;
  import svi_asm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  svi_word_assembler_if #(.WIDTH(WORD_WIDTH), .DEPTH(FIFO_DEPTH)) bus();

  svi_word_assembler #(.WIDTH(WORD_WIDTH), .DEPTH(FIFO_DEPTH)) dut (
    .i_clk (clk),
    .i_arst(rst),
    .bus   (bus)
  );

  // Reference: bits gathered so far in the current word, queued words, sticky overflow.
  bit    partial_m[$];
  word_t fifo_m[$];
  bit    ovf_m;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    partial_m.delete();
    fifo_m.delete();
    ovf_m = 1'b0;
  endtask

  task automatic modelStep(input bit e, input bit b, input bit v, input bit s, input bit r);
    bit    do_pop;
    bit    do_push;
    word_t w;
    do_pop  = (fifo_m.size() > 0) && r;
    do_push = 1'b0;
    w       = '0;
    if (s) partial_m.delete();
    if (e && v) partial_m.push_back(b);
    if (partial_m.size() == WORD_WIDTH) begin
      for (int i = 0; i < WORD_WIDTH; i++) w[i] = partial_m[i];
      partial_m.delete();
      do_push = 1'b1;
    end
    if (do_pop) void'(fifo_m.pop_front());
    if (do_push) begin
      if (fifo_m.size() < FIFO_DEPTH) fifo_m.push_back(w);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic checkAll();
    word_t exp_word;
    exp_word = (fifo_m.size() > 0) ? fifo_m[0] : '0;
    checkOutput("o_word", 32'(bus.o_word), 32'(exp_word));
    checkOutput("o_word_vld", 32'(bus.o_word_vld), 32'(fifo_m.size() > 0));
    checkOutput("o_level", 32'(bus.o_level), 32'(fifo_m.size()));
    checkOutput("o_overflow", 32'(bus.o_overflow), 32'(ovf_m));
    checkOutput("o_busy", 32'(bus.o_busy), 32'(partial_m.size() > 0));
  endtask

  task automatic applyStimulus(input bit e, input bit b, input bit v, input bit s, input bit r);
    bus.en         = e;
    bus.i_bit      = b;
    bus.i_bit_vld  = v;
    bus.i_sync     = s;
    bus.i_word_rdy = r;
    @(posedge clk);
    modelStep(e, b, v, s, r);
    #1;
    checkAll();
  endtask

  task automatic sendWord(input word_t w, input bit r, input bit r_last);
    for (int i = 0; i < WORD_WIDTH; i++)
      applyStimulus(1'b1, w[i], 1'b1, 1'b0, (i == WORD_WIDTH - 1) ? r_last : r);
  endtask

  task automatic idleCycle(input bit r);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, r);
  endtask

  task automatic checkZeros(input string tag);
    checkOutput({tag, "_word"}, 32'(bus.o_word), 32'h0);
    checkOutput({tag, "_vld"}, 32'(bus.o_word_vld), 32'h0);
    checkOutput({tag, "_level"}, 32'(bus.o_level), 32'h0);
    checkOutput({tag, "_ovf"}, 32'(bus.o_overflow), 32'h0);
    checkOutput({tag, "_busy"}, 32'(bus.o_busy), 32'h0);
  endtask

  // Asserts reset between clock edges so the outputs must clear without a clock.
  task automatic applyReset(input string tag);
    #2;
    rst            = 1'b1;
    bus.en         = 1'b0;
    bus.i_bit      = 1'b0;
    bus.i_bit_vld  = 1'b0;
    bus.i_sync     = 1'b0;
    bus.i_word_rdy = 1'b0;
    #1;
    checkZeros(tag);
    modelReset();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    word_t pattern;
    bus.en         = 1'b0;
    bus.i_bit      = 1'b0;
    bus.i_bit_vld  = 1'b0;
    bus.i_sync     = 1'b0;
    bus.i_word_rdy = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkZeros("reset");
    #2;
    rst = 1'b0;

    $display("[TB] single word 0x4D");
    pattern = 8'h4D;
    sendWord(pattern, 1'b1, 1'b1);
    checkOutput("t1_word", 32'(bus.o_word), 32'h4D);
    checkOutput("t1_vld", 32'(bus.o_word_vld), 32'h1);
    idleCycle(1'b1);
    checkOutput("t1_level_after", 32'(bus.o_level), 32'h0);

    $display("[TB] enable gap mid-word");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, pattern[i], 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, ~pattern[4], 1'b1, 1'b0, 1'b1);
      checkOutput("t2_busy_gap", 32'(bus.o_busy), 32'h1);
    end
    for (int i = 4; i < 8; i++) applyStimulus(1'b1, pattern[i], 1'b1, 1'b0, 1'b1);
    checkOutput("t2_word", 32'(bus.o_word), 32'h4D);
    idleCycle(1'b1);

    $display("[TB] overflow with stalled consumer");
    for (int k = 1; k <= 5; k++) sendWord(word_t'(k), 1'b0, 1'b0);
    checkOutput("t3_level", 32'(bus.o_level), 32'h4);
    checkOutput("t3_ovf", 32'(bus.o_overflow), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("t3_drain", 32'(bus.o_word), 32'(k));
      idleCycle(1'b1);
    end
    checkOutput("t3_ovf_sticky", 32'(bus.o_overflow), 32'h1);
    checkOutput("t3_empty", 32'(bus.o_word_vld), 32'h0);

    $display("[TB] push into full FIFO with simultaneous pop");
    applyReset("t4_rst");
    for (int k = 0; k < 4; k++) sendWord(word_t'(8'h10 + k), 1'b0, 1'b0);
    sendWord(8'h14, 1'b0, 1'b1);
    checkOutput("t4_level", 32'(bus.o_level), 32'h4);
    checkOutput("t4_ovf", 32'(bus.o_overflow), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("t4_drain", 32'(bus.o_word), 32'(8'h10 + k));
      idleCycle(1'b1);
    end

    $display("[TB] resync with coincident bit");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("t5_busy", 32'(bus.o_busy), 32'h1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t5_word", 32'(bus.o_word), 32'h01);
    idleCycle(1'b1);

    $display("[TB] asynchronous reset mid-word");
    sendWord(8'h3C, 1'b0, 1'b0);
    sendWord(8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_level_before", 32'(bus.o_level), 32'h2);
    applyReset("t6_rst");
    sendWord(8'hA5, 1'b1, 1'b1);
    checkOutput("t6_fresh_word", 32'(bus.o_word), 32'hA5);
    checkOutput("t6_fresh_level", 32'(bus.o_level), 32'h1);
    idleCycle(1'b1);

    $display("[TB] random traffic");
    applyReset("rnd_rst");
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 4) != 0,
                    $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/svi_word_assembler.md
Name: svi_word_assembler

Overview:
- Downstream consumer of the bit-indexed output-register stage.
- That stage delivers one data bit per enabled cycle, LSB first, over a counter-indexed write.
- This block reassembles the serial bits into WIDTH-bit words and buffers completed words in a small FIFO.
- Words leave through a valid/ready handshake toward the next pipeline stage.

Parameters:
- WIDTH, 8, bits per assembled word.
- DEPTH, 4, FIFO depth in words; power of two, minimum 2.

Ports:
- i_clk  input  1  sole clock; rising edge.
- i_arst  input  1  asynchronous reset, active-high.
- en  input  1  collection enable; when low, incoming bits are ignored and the bit counter holds.
- i_bit  input  1  serial data bit from the upstream stage.
- i_bit_vld  input  1  i_bit is valid this cycle.
- i_sync  input  1  word-boundary resync; forces the next accepted bit to index 0.
- o_word  output  WIDTH  FIFO head word.
- o_word_vld  output  1  FIFO non-empty.
- i_word_rdy  input  1  downstream accepts o_word this cycle.
- o_level  output  $clog2(DEPTH)+1  FIFO occupancy.
- o_overflow  output  1  sticky flag: a completed word was dropped.
- o_busy  output  1  high while a partial word is held.

Behaviour:
- Reset (async assert, sync release):
  - Bit counter = 0, shift register = 0, FIFO empty.
  - o_word = 0, o_word_vld = 0, o_level = 0, o_overflow = 0, o_busy = 0.
  - A reset mid-word discards the partial word and all buffered words.
- A bit is accepted when en && i_bit_vld; it is written to shift[cnt].
- Bit counter cnt (width $clog2(WIDTH)):
  - Increments on each accepted bit and wraps from WIDTH-1 to 0.
  - No other wrap value exists.
- Assembler state machine:
  - IDLE (cnt==0, no partial bits) -> COLLECT on an accepted bit when WIDTH>1.
  - COLLECT -> IDLE on the accepted bit with cnt==WIDTH-1 (word complete).
  - o_busy = (state==COLLECT).
- Word completion:
  - The completed word {i_bit, shift[WIDTH-2:0]} is pushed to the FIFO in the same cycle.
  - It is visible on o_word / o_word_vld the following cycle if the FIFO was empty (latency 1 cycle from last bit).
- i_sync:
  - When asserted, cnt and shift clear to 0 and the state goes to IDLE; no push occurs.
  - If i_sync coincides with an accepted bit, that bit is stored at index 0 and cnt becomes 1 (sync wins, then the bit is accepted).
- Pop occurs when o_word_vld && i_word_rdy. o_word is driven directly from the head entry; it is 0 when the FIFO is empty.
- Push while full:
  - Without a simultaneous pop, the word is dropped and o_overflow sets; it clears only on reset.
  - With a simultaneous pop, the push succeeds and the level stays at DEPTH.
- Push and pop in the same cycle at a non-full level: the level is unchanged.
- Pop when empty is impossible; i_word_rdy is ignored when o_word_vld = 0.
- Read and write pointers are $clog2(DEPTH)+1 bits with natural wrap; full/empty are derived from the MSB compare.
- en low mid-word: partial bits and cnt are held, and assembly resumes when en returns.

Decomposition:
- Package svi_asm_pkg:
  - asm_state_e enum (IDLE, COLLECT).
  - Localparams CNT_W = $clog2(WIDTH) and PTR_W = $clog2(DEPTH)+1.
  - Word typedef logic [WIDTH-1:0].
- One sub-module svi_word_fifo (parameterised WIDTH/DEPTH): storage, pointers, level, and the full/empty/overflow logic.
- The assembler FSM and shift register stay in the top.

Test Plan:
- Bits 1,0,1,1,0,0,1,0 (index 0 first), en=1, i_word_rdy=1 -> one cycle after the 8th bit: o_word = 8'h4D, o_word_vld = 1 for one cycle, o_level back to 0.
- Same 8 bits with en=0 for 3 cycles after bit 4 -> o_busy stays 1 during the gap; resulting o_word = 8'h4D.
- i_word_rdy=0, push 5 words 8'h01..8'h05 -> o_level = 4, o_overflow = 1, then drain yields 01, 02, 03, 04; o_overflow remains 1.
- FIFO full with i_word_rdy=1 in the same cycle as the 5th completion -> no overflow, o_level stays 4, order preserved.
- After 3 bits, assert i_sync together with bit 1, then send 7 more bits 0 -> o_word = 8'h01.
- Assert i_arst mid-word with 2 words buffered -> all outputs are 0 immediately (asynchronous); the next 8 bits form a fresh word.
